// File: rtl/ddr3_ref_sched_pkg.sv
// Shared settings for the DDR3 refresh scheduler: timing defaults, FSM state
// encoding and nanosecond-to-cycle helpers.
package ddr3_ref_sched_pkg;

  localparam int DDR_FREQ_MHZ_DEF = 100;
  localparam int TREFI_NS_DEF     = 7800;
  localparam int TRFC_NS_DEF      = 110;
  localparam int MAX_POSTPONE_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_REQ  = 3'b010,
    ST_TRFC = 3'b100
  } ref_state_e;

  function automatic int ns_to_cyc_floor(input int mhz, input int ns);
    return (mhz * ns) / 1000;
  endfunction

  function automatic int ns_to_cyc_ceil(input int mhz, input int ns);
    return (mhz * ns + 999) / 1000;
  endfunction

endpackage

// File: rtl/ddr3_ref_timer.sv
// Loadable down-counter with a terminal pulse; AUTO=1 reloads on expiry
// (periodic), AUTO=0 parks at zero (one-shot).
module ddr3_ref_timer #(
  parameter int           W       = 8,
  parameter bit           AUTO    = 1'b0,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         arst_n,
  input  logic         load_i,
  input  logic         run_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = run_i && !load_i && (cnt_q == '0);
    cnt_d  = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (run_i)
      cnt_d = (cnt_q == '0) ? (AUTO ? load_val_i : '0) : cnt_q - 1'b1;
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) cnt_q <= RST_VAL;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ddr3_ref_sched.sv
// DDR3 refresh scheduler: tREFI debt tracking, opportunistic/urgent REF
// requests and tRFC blocking. Optional pull-in refresh via DDR3_REF_PULLIN_EN.
module ddr3_ref_sched
  import ddr3_ref_sched_pkg::*;
#(
  parameter int DDR_FREQ_MHZ = DDR_FREQ_MHZ_DEF,
  parameter int TREFI_NS     = TREFI_NS_DEF,
  parameter int TRFC_NS      = TRFC_NS_DEF,
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF
) (
  input  logic       clock,
  input  logic       arst_n,
  input  logic       enable_i,
  input  logic       busy_i,
  output logic       ref_req_o,
  input  logic       ref_ack_i,
  output logic       ref_block_o,
  output logic [3:0] ref_debt_o,
  output logic       ref_err_o
);

  localparam int TREFI_CYC = ns_to_cyc_floor(DDR_FREQ_MHZ, TREFI_NS);
  localparam int TRFC_CYC  = ns_to_cyc_ceil(DDR_FREQ_MHZ, TRFC_NS);
  localparam int TREFI_W   = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam int TRFC_W    = (TRFC_CYC > 1) ? $clog2(TRFC_CYC) : 1;

  localparam logic [TREFI_W-1:0] TREFI_RLD = TREFI_W'(TREFI_CYC - 1);
  localparam logic [TRFC_W-1:0]  TRFC_RLD  = TRFC_W'(TRFC_CYC - 1);
  localparam logic [3:0]         MAXP      = 4'(MAX_POSTPONE);
  localparam logic [3:0]         URG       = 4'(MAX_POSTPONE - 1);

  ref_state_e state_q, state_d;
  logic [3:0] debt_q, debt_d;
  logic       err_q, err_d;
  logic       req_q, req_d;
  logic       blk_q, blk_d;
  logic       ack_ok, trefi_tick, trfc_done, clear;
`ifdef DDR3_REF_PULLIN_EN
  logic [3:0] credit_q, credit_d;
`endif

  // Interval timer is held at its reload value whenever the scheduler is off.
  ddr3_ref_timer #(.W(TREFI_W), .AUTO(1'b1), .RST_VAL(TREFI_RLD)) u_trefi (
    .clock      (clock),
    .arst_n     (arst_n),
    .load_i     (!enable_i),
    .run_i      (enable_i),
    .load_val_i (TREFI_RLD),
    .tick_o     (trefi_tick)
  );

  ddr3_ref_timer #(.W(TRFC_W), .AUTO(1'b0), .RST_VAL('0)) u_trfc (
    .clock      (clock),
    .arst_n     (arst_n),
    .load_i     (ack_ok),
    .run_i      (state_q == ST_TRFC),
    .load_val_i (TRFC_RLD),
    .tick_o     (trfc_done)
  );

  always_comb begin
    ack_ok  = ref_ack_i && (state_q == ST_REQ);
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (debt_q != '0) && (!busy_i || debt_q >= URG))
          state_d = ST_REQ;
`ifdef DDR3_REF_PULLIN_EN
        else if (enable_i && (debt_q == '0) && !busy_i && (credit_q < MAXP))
          state_d = ST_REQ;
`endif
      end
      // An accepted REF wins over a same-cycle disable: tRFC must still run.
      ST_REQ:  if (ack_ok) state_d = ST_TRFC;
               else if (!enable_i) state_d = ST_IDLE;
      ST_TRFC: if (trfc_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    debt_d = debt_q;
    err_d  = err_q;
`ifdef DDR3_REF_PULLIN_EN
    credit_d = credit_q;
`endif
    if (trefi_tick && !ack_ok) begin
      if (debt_q >= MAXP) err_d = 1'b1;
      else                debt_d = debt_q + 1'b1;
`ifdef DDR3_REF_PULLIN_EN
      if (credit_q != '0) begin
        debt_d   = debt_q;
        err_d    = err_q;
        credit_d = credit_q - 1'b1;
      end
`endif
    end else if (ack_ok && !trefi_tick) begin
      if (debt_q != '0) debt_d = debt_q - 1'b1;
`ifdef DDR3_REF_PULLIN_EN
      else if (credit_q < MAXP) credit_d = credit_q + 1'b1;
`endif
    end

    // Disable clears bookkeeping, but only once any tRFC in flight has ended.
    clear = !enable_i && (state_d != ST_TRFC);
    if (clear) debt_d = '0;
`ifdef DDR3_REF_PULLIN_EN
    if (clear) credit_d = '0;
`endif

    req_d = (state_q == ST_REQ) && !ack_ok && enable_i;
    blk_d = (state_d == ST_TRFC) || (debt_d >= URG);
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      debt_q   <= '0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      blk_q    <= 1'b0;
`ifdef DDR3_REF_PULLIN_EN
      credit_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      debt_q   <= debt_d;
      err_q    <= err_d;
      req_q    <= req_d;
      blk_q    <= blk_d;
`ifdef DDR3_REF_PULLIN_EN
      credit_q <= credit_d;
`endif
    end
  end

  assign ref_req_o   = req_q;
  assign ref_block_o = blk_q;
  assign ref_debt_o  = debt_q;
  assign ref_err_o   = err_q;

endmodule

// File: tb/tb_ddr3_ref_sched.sv
// Bench for ddr3_ref_sched: per-cycle behavioural model plus directed
// scenarios with hand-computed timing (tREFI=780, tRFC=11, limit 8).
module tb_ddr3_ref_sched;

  localparam int TREFI = 780;
  localparam int TRFC  = 11;
  localparam int MAXP  = 8;
`ifdef DDR3_REF_PULLIN_EN
  localparam bit PULLIN = 1'b1;
`else
  localparam bit PULLIN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       arst_n = 1'b0;
  logic       enable_i = 1'b0;
  logic       busy_i = 1'b0;
  logic       ref_ack_i = 1'b0;
  logic       ref_req_o, ref_block_o, ref_err_o;
  logic [3:0] ref_debt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ddr3_ref_sched u_dut (
    .clock       (clock),
    .arst_n      (arst_n),
    .enable_i    (enable_i),
    .busy_i      (busy_i),
    .ref_req_o   (ref_req_o),
    .ref_ack_i   (ref_ack_i),
    .ref_block_o (ref_block_o),
    .ref_debt_o  (ref_debt_o),
    .ref_err_o   (ref_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: debt/credit kept as one signed balance, tick derived
  // from the count of enabled cycles, tRFC as a remaining-cycles counter.
  int m_en_cyc, m_bal, m_phase, m_trfc_left;
  bit m_err, m_req, m_blk;

  always @(posedge clock) begin
    bit en, busy, ack, tick, ack_ok;
    int nphase, debt, credit;
    en = enable_i; busy = busy_i; ack = ref_ack_i;
    if (!arst_n) begin
      m_en_cyc = 0; m_bal = 0; m_phase = 0; m_trfc_left = 0;
      m_err = 0; m_req = 0; m_blk = 0;
    end else begin
      m_en_cyc = en ? m_en_cyc + 1 : 0;
      tick   = en && (m_en_cyc % TREFI == 0);
      ack_ok = ack && (m_phase == 1);
      debt   = (m_bal > 0) ? m_bal : 0;
      credit = (m_bal < 0) ? -m_bal : 0;
      nphase = m_phase;
      if (m_phase == 0) begin
        if (en && debt > 0 && (!busy || debt >= MAXP - 1)) nphase = 1;
        if (PULLIN && en && debt == 0 && !busy && credit < MAXP) nphase = 1;
      end else if (m_phase == 1) begin
        if (ack_ok) nphase = 2;
        else if (!en) nphase = 0;
      end else begin
        m_trfc_left--;
        if (m_trfc_left == 0) nphase = 0;
      end
      if (ack_ok) m_trfc_left = TRFC;
      if (tick && !ack_ok) begin
        if (m_bal == MAXP) m_err = 1;
        else m_bal++;
      end else if (ack_ok && !tick) begin
        if (m_bal > (PULLIN ? -MAXP : 0)) m_bal--;
      end
      if (!en && nphase != 2) m_bal = 0;
      m_req   = (m_phase == 1) && !ack_ok && en;
      m_phase = nphase;
      m_blk   = (m_phase == 2) || (m_bal >= MAXP - 1);
    end
    #1;
    chk("model_req",  ref_req_o,   m_req);
    chk("model_blk",  ref_block_o, m_blk);
    chk("model_debt", ref_debt_o,  (m_bal > 0) ? m_bal : 0);
    chk("model_err",  ref_err_o,   m_err);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset;
    arst_n = 1'b0; enable_i = 1'b0; busy_i = 1'b0; ref_ack_i = 1'b0;
    cyc(2);
    arst_n = 1'b1;
  endtask

  task automatic ack_pulse;
    ref_ack_i = 1'b1;
    cyc(1);
    ref_ack_i = 1'b0;
  endtask

  task automatic wait_req(output int k, input int limit);
    k = 0;
    while (ref_req_o !== 1'b1 && k < limit) begin
      cyc(1);
      k++;
    end
    if (k >= limit) chk("req_timeout", 0, 1);
  endtask

  task automatic blk_len(input int start, output int k);
    k = start;
    while (ref_block_o === 1'b1 && k < 50) begin
      cyc(1);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, nack, nreq;
    do_reset;
    chk("rst_req",  ref_req_o,   0);
    chk("rst_blk",  ref_block_o, 0);
    chk("rst_debt", ref_debt_o,  0);
    chk("rst_err",  ref_err_o,   0);

`ifndef DDR3_REF_PULLIN_EN
    // Idle: first tick on enabled edge 780, request visible after edge 782.
    enable_i = 1'b1;
    wait_req(k, 1000);
    chk("t1_req_lat", k, 782);
    chk("t1_debt1", ref_debt_o, 1);
    ack_pulse;
    chk("t1_debt0", ref_debt_o, 0);
    chk("t1_req_drop", ref_req_o, 0);
    blk_len(0, k);
    chk("t1_blk_len", k, 11);

    // Busy for 7 ticks: debt 7 forces request and block.
    do_reset;
    enable_i = 1'b1; busy_i = 1'b1;
    cyc(6 * TREFI + TREFI - 1);
    chk("t2_debt6", ref_debt_o, 6);
    chk("t2_blk6", ref_block_o, 0);
    chk("t2_req6", ref_req_o, 0);
    cyc(4);
    chk("t2_debt7", ref_debt_o, 7);
    chk("t2_blk7", ref_block_o, 1);
    chk("t2_req7", ref_req_o, 1);
    busy_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wait_req(k, 100);
      ack_pulse;
    end
    cyc(15);
    chk("t2_debt_end", ref_debt_o, 0);
    chk("t2_blk_end", ref_block_o, 0);
    chk("t2_req_end", ref_req_o, 0);

    // No acks for 9 ticks: saturate and flag sticky error.
    do_reset;
    enable_i = 1'b1; busy_i = 1'b1;
    cyc(8 * TREFI + 1);
    chk("t3_debt8", ref_debt_o, 8);
    chk("t3_err_pre", ref_err_o, 0);
    chk("t3_req8", ref_req_o, 1);
    cyc(TREFI);
    chk("t3_debt_sat", ref_debt_o, 8);
    chk("t3_err", ref_err_o, 1);
    enable_i = 1'b0;
    cyc(3);
    chk("t3_err_sticky", ref_err_o, 1);
    chk("t3_debt_clr", ref_debt_o, 0);
    chk("t3_req_clr", ref_req_o, 0);
    do_reset;
    chk("t3_err_rst", ref_err_o, 0);

    // Tick and ack on the same edge at debt 2.
    do_reset;
    enable_i = 1'b1; busy_i = 1'b1;
    cyc(2 * TREFI + 1);
    chk("t4_debt2", ref_debt_o, 2);
    cyc(769);
    busy_i = 1'b0;
    cyc(9);
    chk("t4_req", ref_req_o, 1);
    ref_ack_i = 1'b1;
    cyc(1);
    ref_ack_i = 1'b0;
    busy_i = 1'b1;
    chk("t4_debt_same", ref_debt_o, 2);
    chk("t4_blk", ref_block_o, 1);
    chk("t4_req_drop", ref_req_o, 0);
    cyc(12);
    chk("t4_blk_end", ref_block_o, 0);
    chk("t4_debt_end", ref_debt_o, 2);

    // Spurious ack in idle, then disable midway through tRFC.
    do_reset;
    enable_i = 1'b1; busy_i = 1'b1;
    cyc(20);
    ack_pulse;
    cyc(2);
    chk("t5_spur_debt", ref_debt_o, 0);
    chk("t5_spur_blk", ref_block_o, 0);
    chk("t5_spur_req", ref_req_o, 0);
    cyc(1538);
    chk("t5_debt2", ref_debt_o, 2);
    busy_i = 1'b0;
    wait_req(k, 20);
    ack_pulse;
    chk("t5_debt1", ref_debt_o, 1);
    cyc(4);
    chk("t5_debt_hold", ref_debt_o, 1);
    enable_i = 1'b0;
    blk_len(4, k);
    chk("t5_blk_len", k, 11);
    chk("t5_debt_clr", ref_debt_o, 0);
    chk("t5_req_idle", ref_req_o, 0);
    cyc(3);
    chk("t5_blk_idle", ref_block_o, 0);
`else
    // Pull-in: idle bench earns 8 credits, which absorb the next 8 ticks.
    enable_i = 1'b1; busy_i = 1'b0;
    nack = 0;
    for (int i = 0; i < 300; i++) begin
      if (ref_req_o === 1'b1) begin
        ack_pulse;
        nack++;
      end else cyc(1);
    end
    chk("pi_refs", nack, 8);
    chk("pi_debt0", ref_debt_o, 0);
    busy_i = 1'b1;
    nreq = 0;
    k = 0;
    for (int i = 0; i < 8 * TREFI + 1 - 300; i++) begin
      cyc(1);
      if (ref_req_o === 1'b1) nreq++;
      if (ref_debt_o !== 4'd0) k++;
    end
    chk("pi_no_req", nreq, 0);
    chk("pi_debt_stay0", k, 0);
    cyc(TREFI);
    chk("pi_debt_after", ref_debt_o, 1);
`endif

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
